// File: rtl/wb_fifo_drain.sv
// rtl/wb_fifo_drain.sv - drains one cache line from the write-back FIFO as an incrementing memory burst
// Single output register stage; pops are steered so a stalled beat never loses FIFO data.
module wb_fifo_drain #(
   parameter int W_DATA     = 32,
   parameter int W_ADDR     = 32,
   parameter int C_BURSTLEN = 8
) (
   input  logic              sClk_i,
   input  logic              snRst_i,
   input  logic              Start_i,
   input  logic [W_ADDR-1:0] LineAddr_i,
   input  logic              FifoEmpty_i,
   input  logic [W_DATA-1:0] FifoData_32i,
   output logic              FifoRead_o,
   output logic              MemValid_o,
   input  logic              MemReady_i,
   output logic [W_ADDR-1:0] MemAddr_o,
   output logic [W_DATA-1:0] MemWData_o,
   output logic              MemLast_o,
   output logic              Busy_oc,
   output logic              Done_o
);

   localparam int BYTES = W_DATA / 8;
   localparam int B_SH  = $clog2(BYTES);
   localparam int OFF_W = $clog2(C_BURSTLEN * BYTES);
   localparam int CNT_W = $clog2(C_BURSTLEN) + 1;

   localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(C_BURSTLEN);
   localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(C_BURSTLEN - 1);
   localparam logic [W_ADDR-1:0] ALIGN_MASK = {W_ADDR{1'b1}} << OFF_W;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BURST = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [W_ADDR-1:0]   base_q, base_d;
   logic [CNT_W-1:0]    issued_q, issued_d;
   logic [CNT_W-1:0]    accepted_q, accepted_d;
   logic                valid_q, valid_d;
   logic [W_ADDR-1:0]   addr_q, addr_d;
   logic [W_DATA-1:0]   wdata_q, wdata_d;
   logic                last_q, last_d;
   logic                load;
   logic                accept;
   logic [W_ADDR-1:0]   beat_addr;

   assign accept    = valid_q & MemReady_i;
   assign beat_addr = base_q + (W_ADDR'(issued_q) << B_SH);

   always_ff @(posedge sClk_i) begin
      if (!snRst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // The final accept is identified both by the last flag and the accept count.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (Start_i) state_d = S_BURST;
         S_BURST: if (accept && last_q && (accepted_q == CNT_LAST)) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      load       = (state_q == S_BURST) && (issued_q < CNT_FULL) && !FifoEmpty_i
                   && (!valid_q || MemReady_i);
      FifoRead_o = load;
      Busy_oc    = (state_q != S_IDLE);
      Done_o     = (state_q == S_DONE);
   end

   always_comb begin
      base_d     = base_q;
      issued_d   = issued_q;
      accepted_d = accepted_q;
      valid_d    = valid_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      last_d     = last_q;
      case (state_q)
         S_IDLE: begin
            if (Start_i) begin
               base_d     = LineAddr_i & ALIGN_MASK;
               issued_d   = '0;
               accepted_d = '0;
            end
         end
         S_BURST: begin
            if (accept) begin
               accepted_d = accepted_q + CNT_W'(1);
            end
            if (load) begin
               wdata_d  = FifoData_32i;
               addr_d   = beat_addr;
               last_d   = (issued_q == CNT_LAST);
               valid_d  = 1'b1;
               issued_d = issued_q + CNT_W'(1);
            end else if (accept) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge sClk_i) begin
      if (!snRst_i) begin
         base_q     <= '0;
         issued_q   <= '0;
         accepted_q <= '0;
         valid_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         last_q     <= 1'b0;
      end else begin
         base_q     <= base_d;
         issued_q   <= issued_d;
         accepted_q <= accepted_d;
         valid_q    <= valid_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         last_q     <= last_d;
      end
   end

   assign MemValid_o = valid_q;
   assign MemAddr_o  = addr_q;
   assign MemWData_o = wdata_q;
   assign MemLast_o  = last_q;

endmodule
